// File: rtl/pulse_gen_pkg.sv
// Shared types and defaults for the delay-and-pulse generator.
// Imported by the top and the LED stretcher.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam int LED_STRETCH_DEF = 25_000_000;
  localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/pulse_stretcher.sv
// Registered LED driver: follows src, then holds high for
// HOLD_CYCLES more cycles after src falls.
module pulse_stretcher
  import pulse_gen_pkg::*;
#(
  parameter int HOLD_CYCLES = LED_STRETCH_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic src,
  output logic led
);

  localparam int HW =
    (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD = HW'(HOLD_CYCLES);

  logic [HW-1:0] hold_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      led    <= 1'b0;
    end else if (src) begin
      hold_q <= HOLD;
      led    <= 1'b1;
    end else if (hold_q != '0) begin
      hold_q <= hold_q - HW'(1);
      led    <= 1'b1;
    end else begin
      led    <= 1'b0;
    end
  end

endmodule

// File: rtl/pulse_generator.sv
// Single-shot delay-then-pulse generator with stretched
// status LEDs for the delay and pulse phases.
module pulse_generator
  import pulse_gen_pkg::*;
#(
  parameter int LED_STRETCH_CYCLES = LED_STRETCH_DEF,
  parameter int CNT_W              = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] delay_cycles,
  input  logic [CNT_W-1:0] pulse_width_cycles,
  output logic             pulse_out,
  output logic             pulse_led,
  output logic             delay_led
);

  state_t           state;
  state_t           state_nx;
  logic             start_q;
  logic             trig;
  logic             cnt_last;
  logic             d_nz;
  logic             w_nz;
  logic             load_seq;
  logic             load_w;
  logic             run;
  logic             pulse_nx;
  logic             delay_raw;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] width_q;

  assign trig     = start & ~start_q;
  assign cnt_last = (cnt == CNT_W'(1));
  assign d_nz     = |delay_cycles;
  assign w_nz     = |pulse_width_cycles;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (trig && d_nz)      state_nx = DELAY;
        else if (trig && w_nz) state_nx = PULSE;
      end
      DELAY: begin
        if (cnt_last)
          state_nx = (|width_q) ? PULSE : IDLE;
      end
      PULSE: begin
        if (cnt_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    delay_raw = (state == DELAY);
    pulse_nx  = (state_nx == PULSE);
    load_seq  = (state == IDLE) && trig;
    load_w    = (state == DELAY) && cnt_last;
    run       = (state != IDLE) && !load_w;
  end

  // Width is latched at trigger time; the counter is
  // reloaded with it at the DELAY-to-PULSE boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      cnt     <= '0;
      width_q <= '0;
    end else begin
      start_q <= start;
      unique case (1'b1)
        load_seq: begin
          width_q <= pulse_width_cycles;
          cnt     <= d_nz ? delay_cycles
                          : pulse_width_cycles;
        end
        load_w:  cnt <= width_q;
        run:     cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pulse_out <= 1'b0;
    else          pulse_out <= pulse_nx;
  end

  pulse_stretcher #(
    .HOLD_CYCLES(LED_STRETCH_CYCLES)
  ) u_pulse_led (
    .clk    (clk),
    .reset_n(reset_n),
    .src    (pulse_out),
    .led    (pulse_led)
  );

  pulse_stretcher #(
    .HOLD_CYCLES(LED_STRETCH_CYCLES)
  ) u_delay_led (
    .clk    (clk),
    .reset_n(reset_n),
    .src    (delay_raw),
    .led    (delay_led)
  );

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: three LED hold settings share
// one stimulus stream and a timeline-based reference model.
module tb_pulse_generator;

  localparam int CW = 8;
  localparam int H0 = 0;
  localparam int H4 = 4;
  localparam int H8 = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [CW-1:0] delay_cycles;
  logic [CW-1:0] pulse_width_cycles;
  logic          po0, pl0, dl0;
  logic          po4, pl4, dl4;
  logic          po8, pl8, dl8;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference timeline: windows of the current sequence in
  // edge indices, plus the last edge each source was high.
  longint cyc;
  longint wk, wd, ww;
  longint seq_end;
  longint hi_p, hi_d;
  logic   sp, mp, md;
  logic   e_l0p, e_l0d, e_l4p, e_l4d, e_l8p, e_l8d;

  always #5 clk = ~clk;

  pulse_generator #(
    .LED_STRETCH_CYCLES(H0), .CNT_W(CW)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .delay_cycles(delay_cycles),
    .pulse_width_cycles(pulse_width_cycles),
    .pulse_out(po0), .pulse_led(pl0), .delay_led(dl0)
  );

  pulse_generator #(
    .LED_STRETCH_CYCLES(H4), .CNT_W(CW)
  ) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .delay_cycles(delay_cycles),
    .pulse_width_cycles(pulse_width_cycles),
    .pulse_out(po4), .pulse_led(pl4), .delay_led(dl4)
  );

  pulse_generator #(
    .LED_STRETCH_CYCLES(H8), .CNT_W(CW)
  ) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start),
    .delay_cycles(delay_cycles),
    .pulse_width_cycles(pulse_width_cycles),
    .pulse_out(po8), .pulse_led(pl8), .delay_led(dl8)
  );

  task automatic chk(input string tag,
                     input logic obs,
                     input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    wk      = -100000;
    wd      = 0;
    ww      = 0;
    seq_end = 0;
    hi_p    = -1000000;
    hi_d    = -1000000;
    sp      = 1'b0;
    mp      = 1'b0;
    md      = 1'b0;
  endtask

  task automatic tick();
    logic tr;
    if (mp) hi_p = cyc - 1;
    if (md) hi_d = cyc - 1;
    e_l0p = (hi_p >= cyc - 1 - H0);
    e_l0d = (hi_d >= cyc - 1 - H0);
    e_l4p = (hi_p >= cyc - 1 - H4);
    e_l4d = (hi_d >= cyc - 1 - H4);
    e_l8p = (hi_p >= cyc - 1 - H8);
    e_l8d = (hi_d >= cyc - 1 - H8);
    tr = start && !sp;
    sp = start;
    if (tr && cyc >= seq_end) begin
      wk = cyc;
      wd = longint'(delay_cycles);
      ww = longint'(pulse_width_cycles);
      seq_end = cyc + wd + ww + 1;
    end
    md = (cyc >= wk) && (cyc < wk + wd);
    mp = (cyc >= wk + wd) && (cyc < wk + wd + ww);
    @(posedge clk);
    #1;
    chk("pulse_out_h0", po0, mp);
    chk("pulse_out_h4", po4, mp);
    chk("pulse_out_h8", po8, mp);
    chk("pulse_led_h0", pl0, e_l0p);
    chk("delay_led_h0", dl0, e_l0d);
    chk("pulse_led_h4", pl4, e_l4p);
    chk("delay_led_h4", dl4, e_l4d);
    chk("pulse_led_h8", pl8, e_l8p);
    chk("delay_led_h8", dl8, e_l8d);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fire(input int d, input int w);
    delay_cycles       = CW'(d);
    pulse_width_cycles = CW'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_po0"}, po0, 1'b0);
    chk({tag, "_pl0"}, pl0, 1'b0);
    chk({tag, "_dl0"}, dl0, 1'b0);
    chk({tag, "_po4"}, po4, 1'b0);
    chk({tag, "_pl4"}, pl4, 1'b0);
    chk({tag, "_dl4"}, dl4, 1'b0);
    chk({tag, "_po8"}, po8, 1'b0);
    chk({tag, "_pl8"}, pl8, 1'b0);
    chk({tag, "_dl8"}, dl8, 1'b0);
  endtask

  initial begin
    cyc                = 0;
    reset_n            = 1'b1;
    start              = 1'b0;
    delay_cycles       = '0;
    pulse_width_cycles = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    fire(10, 20);
    run(40);

    fire(0, 5);
    run(10);
    fire(3, 0);
    run(8);
    fire(0, 0);
    run(5);

    fire(6, 8);
    run(3);
    fire(1, 1);
    run(6);
    fire(2, 2);
    run(12);

    delay_cycles       = CW'(5);
    pulse_width_cycles = CW'(5);
    start = 1'b1;
    run(50);
    start = 1'b0;
    run(5);

    fire(4, 6);
    run(2);
    delay_cycles       = CW'(9);
    pulse_width_cycles = CW'(2);
    run(15);
    start = 1'b1;
    tick();
    start = 1'b0;
    run(15);

    fire(0, 2);
    run(4);
    fire(0, 2);
    run(14);

    fire(255, 3);
    run(262);

    fire(2, 20);
    run(10);
    reset_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1 chk_zero("in_rst");
    start              = 1'b1;
    delay_cycles       = CW'(2);
    pulse_width_cycles = CW'(2);
    reset_n = 1'b1;
    model_reset();
    tick();
    start = 1'b0;
    run(16);

    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      delay_cycles       = CW'($urandom_range(0, 12));
      pulse_width_cycles = CW'($urandom_range(0, 12));
      tick();
    end
    start = 1'b0;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Single-shot programmable delay-and-pulse generator for the DE10-Nano blinky design.
- A start event arms it. It waits a programmable number of clock cycles, then drives one output pulse of programmable width, then returns to idle.
- Two status outputs drive board LEDs. They are stretched so that short delay and pulse phases remain visible.

Parameters:
- LED_STRETCH_CYCLES, 25_000_000: minimum on-time of each LED output after its source phase ends. The default gives 0.5 s at 50 MHz. Must be 0 or more; 0 disables stretching.
- CNT_W, 32: width of the delay and width inputs and of the internal counters.

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  trigger. Only a rising edge is acted on.
- delay_cycles  in  CNT_W  cycles from trigger to pulse start, unsigned.
- pulse_width_cycles  in  CNT_W  pulse length in cycles, unsigned.
- pulse_out  out  1  generated pulse, registered.
- pulse_led  out  1  stretched copy of pulse_out.
- delay_led  out  1  stretched indicator of the DELAY phase.

Behaviour:
- Interface: one clock domain, clk. reset_n is asynchronous and active-low. Reset assertion is asynchronous; release is clocked by clk and is assumed synchronised upstream.
- Reset values:
  - pulse_out, pulse_led and delay_led are all 0.
  - FSM is in IDLE, counters are 0.
  - The start-edge register is 0.
- Start detection:
  - trig = start & ~start_q, where start_q is start registered once.
  - No extra latency is added.
  - A start held high across reset release counts as an edge on the first sampled cycle.
- FSM states: IDLE, DELAY, PULSE.
- IDLE, on trig at clock edge k:
  - Latch delay_cycles (D) and pulse_width_cycles (W). Later input changes are ignored until the sequence finishes.
  - If D > 0: go to DELAY and load the counter with D.
  - Else if W > 0: go to PULSE with pulse_out = 1 after edge k.
  - Else (D = 0, W = 0): stay in IDLE; no output activity.
- DELAY:
  - Phase lasts exactly D cycles, edges k through k+D-1.
  - At edge k+D, go to PULSE if W > 0, else go to IDLE.
- PULSE:
  - pulse_out is 1 for exactly W cycles: from after edge k+D until edge k+D+W, where it returns to 0.
  - At that edge the FSM goes to IDLE.
- Re-triggering: trig in DELAY or PULSE is ignored (non-retriggerable). A new trig is accepted in the first IDLE cycle after completion.
- delay_raw = (state == DELAY). pulse_out is 1 exactly when state == PULSE, and is driven from a flop.
- LED stretching:
  - Each LED is high while its source is high.
  - After the source falls, the LED stays high for LED_STRETCH_CYCLES further cycles.
  - A new source assertion during the hold reloads the hold.
  - With LED_STRETCH_CYCLES = 0, each LED equals its source registered one cycle.
- Arithmetic: counters are CNT_W-bit down-counters. The maximum value 2^CNT_W-1 is legal; there is no wrap and no saturation logic.
- Reset mid-operation: all state clears immediately, pulse_out drops asynchronously, and LED holds are cancelled.

Decomposition:
- Package pulse_gen_pkg:
  - state enum typedef (IDLE, DELAY, PULSE).
  - Default constants for LED_STRETCH_CYCLES and CNT_W.
- Sub-module pulse_stretcher (parameter HOLD_CYCLES), instantiated twice: once for pulse_led, once for delay_led.
- FSM, counters and edge detect live in the top module.

Test Plan (LED_STRETCH_CYCLES = 4 unless noted; trig at edge k):
- D = 10, W = 20, start high for one cycle → pulse_out low for 10 cycles, then high for exactly 20 cycles (edges k+10 to k+30); delay_led high from k+1 through k+10+4.
- D = 0, W = 5 → pulse_out high after edge k for 5 cycles; delay_led never asserts. D = 3, W = 0 → 3 DELAY cycles, pulse_out stays 0. D = 0, W = 0 → nothing.
- Second start pulse during DELAY and again during PULSE → ignored, single pulse of W cycles. Start held high for 50 cycles → only one sequence.
- Change delay_cycles and pulse_width_cycles mid-sequence → the current sequence uses the latched values; the next trig uses the new values.
- reset_n low mid-PULSE → pulse_out, pulse_led and delay_led are 0 immediately. After release, a new start with D = 2, W = 2 behaves normally.
- LED_STRETCH_CYCLES = 0 → pulse_led equals pulse_out delayed by one cycle. Two pulses whose LED holds overlap (LED_STRETCH_CYCLES = 8) → pulse_led stays continuously high.
